// File: rtl/regfile_sb.sv
// Parametrised register file with hardwired zero register, same-cycle
// write-to-read bypass and a per-register pending-write scoreboard.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   rd_addr1/2               read indices (combinational read)
//   rd_data1/2               read data (zero reg -> 0, else bypass, else array)
//   rd_pend1/2               register has an outstanding (reserved) write
//   wr_en, wr_addr, wr_data  writeback port; clears the pending bit
//   rsv_en, rsv_addr         reserve port (issue); sets the pending bit
//   pend_count               registered popcount of the pending vector
module regfile_sb #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_EN  = 1'b1,
  parameter int unsigned ZERO_IDX = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_pend1,
  output logic              rd_pend2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   pend_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   pend_count_q, pend_count_d;

  logic wr_zero, rsv_zero;
  logic wr_eff, rsv_eff;
  logic same_addr;
  logic cnt_inc, cnt_dec;

  // Writes and reserves aimed at the zero register are dropped entirely.
  always_comb begin
    wr_zero   = ZERO_EN && (wr_addr == ZERO_ADDR);
    rsv_zero  = ZERO_EN && (rsv_addr == ZERO_ADDR);
    wr_eff    = wr_en && !wr_zero;
    rsv_eff   = rsv_en && !rsv_zero;
    same_addr = (wr_addr == rsv_addr);
  end

  // Pending vector: write clears, reserve sets; reserve applied last so a new
  // producer issued in the writeback cycle of the old one keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wr_eff) begin
      pend_d[wr_addr] = 1'b0;
    end
    if (rsv_eff) begin
      pend_d[rsv_addr] = 1'b1;
    end
  end

  // Incremental popcount: +1 only for a fresh reservation, -1 only when a
  // pending bit is actually retired and not immediately re-reserved.
  always_comb begin
    cnt_inc      = rsv_eff && !pend_q[rsv_addr];
    cnt_dec      = wr_eff && pend_q[wr_addr] && !(rsv_eff && same_addr);
    pend_count_d = pend_count_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_eff) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q       <= '0;
      pend_count_q <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_count_q <= pend_count_d;
    end
  end

  // Read port 1
  always_comb begin
    rd_data1 = mem_q[rd_addr1];
    rd_pend1 = pend_q[rd_addr1];
    if (ZERO_EN && (rd_addr1 == ZERO_ADDR)) begin
      rd_data1 = '0;
      rd_pend1 = 1'b0;
    end else if (wr_en && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      // A bypassing write retires the hazard unless a new reserve lands too.
      if (!(rsv_en && (rsv_addr == rd_addr1))) begin
        rd_pend1 = 1'b0;
      end
    end
  end

  // Read port 2
  always_comb begin
    rd_data2 = mem_q[rd_addr2];
    rd_pend2 = pend_q[rd_addr2];
    if (ZERO_EN && (rd_addr2 == ZERO_ADDR)) begin
      rd_data2 = '0;
      rd_pend2 = 1'b0;
    end else if (wr_en && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
      if (!(rsv_en && (rsv_addr == rd_addr2))) begin
        rd_pend2 = 1'b0;
      end
    end
  end

  assign pend_count = pend_count_q;

endmodule
